adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one external 64-bit ripple-carry adder (`bitadder64`, instanced alongside at the datapath top) among NUM_REQ requesters.
- Round-robin arbitration; registers the winner's operands onto the adder inputs.
- Waits SETTLE_CYCLES clocks for the gate-delay ripple to resolve, then captures the sum and returns it with a one-cycle done pulse.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WIDTH, 64, operand/result width; must match the adder.
- SETTLE_CYCLES, 4, clocks operands are held on the adder before the sum is sampled (>=1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- req  input  NUM_REQ  per-requester request level; held high until that requester's done.
- req_a  input  NUM_REQ*WIDTH  flattened operand A; slice i = bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  flattened operand B, same slicing.
- gnt  output  NUM_REQ  one-hot grant; high for the owner from grant through done.
- done  output  NUM_REQ  one-hot, one-cycle pulse when result is valid for that requester.
- result  output  WIDTH  captured sum; holds until the next capture.
- busy  output  1  high whenever state != IDLE.
- add_a  output  WIDTH  registered operand A driven to adder.
- add_b  output  WIDTH  registered operand B driven to adder.
- add_out  input  WIDTH  adder sum (carry-out discarded, modulo 2^WIDTH).

Behaviour:
- Reset (reset==0 at edge): state=IDLE, gnt=0, done=0, result=0, add_a=0, add_b=0, busy=0, rr pointer=0, settle counter=0. Reset wins over every other event, including mid-operation: the operation is dropped and no done is issued.
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - With no req bits set, stay in IDLE.
  - Otherwise select the first set req bit at or after the rr pointer, wrapping from NUM_REQ-1 to 0.
  - On that edge: latch that requester's slices into add_a/add_b, set gnt to its one-hot, load counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - Counter decrements each edge.
  - On the edge where counter==0: result <= add_out, done <= gnt, go to DONE.
  - add_a/add_b stay stable for the whole of SETTLE.
- DONE (exactly one cycle):
  - done and gnt high, result valid.
  - Next edge: gnt=0, done=0, rr pointer = granted index+1 (mod NUM_REQ), go to IDLE.
  - add_a/add_b retain their last values (no glitching of the adder).
- Latency:
  - gnt rises at edge E0.
  - done and result are valid after edge E0+SETTLE_CYCLES.
  - IDLE is restored after E0+SETTLE_CYCLES+1; the earliest next grant is at edge E0+SETTLE_CYCLES+2.
  - SETTLE_CYCLES=1 gives done one cycle after gnt.
- Request handling:
  - req changes after grant are ignored.
  - An owner dropping req mid-operation still gets done. Operand inputs are not re-sampled.
  - Simultaneous requests resolve purely by rr pointer, which gives starvation-free fairness: each requester waits at most NUM_REQ-1 operations.
- Arithmetic: result = (a+b) mod 2^WIDTH; no carry-in, no carry-out.
- Counter width: $clog2(SETTLE_CYCLES+1).

Optional Feature:
- ADDER_ARB_OVF_EN defined:
  - Adds output port `ovf` (1 bit), registered alongside result in the SETTLE->DONE edge.
  - ovf = (add_a[WIDTH-1]==add_b[WIDTH-1]) && (add_out[WIDTH-1]!=add_a[WIDTH-1]), i.e. signed overflow.
  - Reset value 0; held with result.
- Undefined: no ovf port, no overflow logic.

Test Plan:
- Reset mid-op:
  - req=4'b0001, a0=16, b0=32; drive reset=0 while in SETTLE.
  - Required: gnt=0, busy=0, no done pulse, result=0.
  - After release, req still high: regrant to requester 0 with rr=0, and result=48.
- Single requester:
  - req=4'b0010, a1=416, b1=408, SETTLE_CYCLES=4.
  - Required: gnt=4'b0010 after E0; done[1] pulse after E0+4 with result=824; busy low after E0+5.
- Contention:
  - req=4'b1111 held, all operand pairs distinct (e.g. ai=i, bi=100).
  - Required: grants in order 0,1,2,3,0; each result = i+100; exactly one done pulse per operation.
- Wrap and skip:
  - After requester 3 is served, req=4'b0101.
  - Required: grant to 0 next, then 2; requester 1 and 3 never granted.
- Drop mid-op and modulo wrap:
  - req[2] dropped during SETTLE.
  - Required: done[2] still pulses.
  - With a2=64'hFFFF_FFFF_FFFF_FFFF, b2=1: result=0.
  - With ADDER_ARB_OVF_EN: ovf=0 here; a=64'h7FFF_FFFF_FFFF_FFFF, b=1 gives ovf=1.

Source files
------------

// File: rtl/adder_share_arbiter_if.sv
// Requester/adder-side bundle for adder_share_arbiter; ovf only exists when ADDER_ARB_OVF_EN is defined.
// master = requesters plus the external adder, slave = the arbiter.
interface adder_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic [WIDTH-1:0]         result;
    logic                     busy;
    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic [WIDTH-1:0]         add_out;
`ifdef ADDER_ARB_OVF_EN
    logic                     ovf;

    modport master (
        output req, req_a, req_b, add_out,
        input  gnt, done, result, busy, add_a, add_b, ovf
    );
    modport slave (
        input  req, req_a, req_b, add_out,
        output gnt, done, result, busy, add_a, add_b, ovf
    );
`else
    modport master (
        output req, req_a, req_b, add_out,
        input  gnt, done, result, busy, add_a, add_b
    );
    modport slave (
        input  req, req_a, req_b, add_out,
        output gnt, done, result, busy, add_a, add_b
    );
`endif
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin share of one external ripple adder; grant->done = SETTLE_CYCLES clocks, requests wait while busy.
// Optional signed-overflow flag (ovf) is built when ADDER_ARB_OVF_EN is defined.
module adder_share_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int WIDTH         = 64,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    adder_share_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   add_a_q, add_a_d;
    logic [WIDTH-1:0]   add_b_q, add_b_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
`ifdef ADDER_ARB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               pick_vld;
    logic [IW-1:0]      pick_idx;

    // Scan downward so the lowest offset from the rr pointer is the last to win.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[(int'(rr_q) + k) % NUM_REQ]) begin
                pick_vld = 1'b1;
                pick_idx = IW'((int'(rr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        result_d = result_q;
        add_a_d  = add_a_q;
        add_b_d  = add_b_q;
        rr_d     = rr_q;
        gidx_d   = gidx_q;
        cnt_d    = cnt_q;
`ifdef ADDER_ARB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    add_a_d         = bus.req_a[int'(pick_idx)*WIDTH +: WIDTH];
                    add_b_d         = bus.req_b[int'(pick_idx)*WIDTH +: WIDTH];
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gidx_d          = pick_idx;
                    cnt_d           = CW'(SETTLE_CYCLES - 1);
                    state_d         = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    result_d = bus.add_out;
                    done_d   = gnt_q;
`ifdef ADDER_ARB_OVF_EN
                    ovf_d    = (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) &&
                               (bus.add_out[WIDTH-1] != add_a_q[WIDTH-1]);
`endif
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                gnt_d   = '0;
                rr_d    = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Adder operands are never cleared outside reset so the ripple never sees a glitch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            add_a_q  <= '0;
            add_b_q  <= '0;
            rr_q     <= '0;
            gidx_q   <= '0;
            cnt_q    <= '0;
`ifdef ADDER_ARB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
            rr_q     <= rr_d;
            gidx_q   <= gidx_d;
            cnt_q    <= cnt_d;
`ifdef ADDER_ARB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.add_a  = add_a_q;
    assign bus.add_b  = add_b_q;
`ifdef ADDER_ARB_OVF_EN
    assign bus.ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed scenarios plus random traffic against a queue-free round-robin reference model.
module tb_adder_share_arbiter;
    localparam int N = 4;
    localparam int W = 64;
    localparam int S = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    adder_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural stand-in for the external bitadder64.
    assign bus.add_out = bus.add_a + bus.add_b;

    int n_chk  = 0;
    int n_fail = 0;

    int           rr_m;
    logic [W-1:0] a_m [N];
    logic [W-1:0] b_m [N];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ops();
        for (int k = 0; k < N; k++) begin
            bus.req_a[k*W +: W] = a_m[k];
            bus.req_b[k*W +: W] = b_m[k];
        end
    endtask

    function automatic int predict(input logic [N-1:0] r);
        for (int off = 0; off < N; off++) begin
            if (r[(rr_m + off) % N]) return (rr_m + off) % N;
        end
        return 0;
    endfunction

    task automatic run_op(input logic [N-1:0] r, input logic [N-1:0] drop);
        int           w;
        int           cyc;
        logic [W-1:0] sum;
        logic [N-1:0] onehot;
        w      = predict(r);
        sum    = a_m[w] + b_m[w];
        onehot = N'(1) << w;
        drive_ops();
        bus.req = r;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.gnt == '0 && cyc < 20);
        chk("gnt", W'(bus.gnt), W'(onehot));
        chk("busy_on", W'(bus.busy), W'(1));
        chk("add_a", bus.add_a, a_m[w]);
        chk("add_b", bus.add_b, b_m[w]);
        bus.req = r & ~drop;
        cyc = 0;
        while (bus.done == '0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("settle_cycles", W'(cyc), W'(S));
        chk("done", W'(bus.done), W'(onehot));
        chk("gnt_at_done", W'(bus.gnt), W'(onehot));
        chk("result", bus.result, sum);
        chk("add_a_stable", bus.add_a, a_m[w]);
`ifdef ADDER_ARB_OVF_EN
        chk("ovf", W'(bus.ovf),
            W'((a_m[w][W-1] == b_m[w][W-1]) && (sum[W-1] != a_m[w][W-1])));
`endif
        @(negedge clk);
        chk("done_pulse_end", W'(bus.done), W'(0));
        chk("gnt_release", W'(bus.gnt), W'(0));
        chk("busy_off", W'(bus.busy), W'(0));
        chk("result_hold", bus.result, sum);
        rr_m = (w + 1) % N;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] d;
        int           cyc;

        bus.req   = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        for (int k = 0; k < N; k++) begin
            a_m[k] = '0;
            b_m[k] = '0;
        end
        rr_m = 0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", W'(bus.gnt), W'(0));
        chk("rst_done", W'(bus.done), W'(0));
        chk("rst_busy", W'(bus.busy), W'(0));
        chk("rst_result", bus.result, '0);
        chk("rst_add_a", bus.add_a, '0);
        chk("rst_add_b", bus.add_b, '0);
        reset = 1'b1;

        // Contention: every requester asks, expect 0,1,2,3 in turn.
        for (int k = 0; k < N; k++) begin
            a_m[k] = W'(k);
            b_m[k] = W'(100);
        end
        for (int k = 0; k < N; k++) run_op(4'b1111, 4'b0000);

        // Wrap to 0, skip 1, serve 2.
        run_op(4'b0101, 4'b0000);
        run_op(4'b0101, 4'b0000);

        // Lone requester.
        a_m[1] = W'(416);
        b_m[1] = W'(408);
        run_op(4'b0010, 4'b0000);

        // Owner drops req mid-operation; modulo wrap.
        a_m[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        b_m[2] = 64'd1;
        run_op(4'b0100, 4'b0100);
        a_m[2] = 64'h7FFF_FFFF_FFFF_FFFF;
        b_m[2] = 64'd1;
        run_op(4'b0100, 4'b0100);

        // Reset while settling drops the operation.
        a_m[0] = 64'd16;
        b_m[0] = 64'd32;
        drive_ops();
        bus.req = 4'b0001;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.gnt == '0 && cyc < 20);
        chk("rst_mid_gnt_before", W'(bus.gnt), W'(4'b0001));
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_gnt", W'(bus.gnt), W'(0));
            chk("rst_mid_done", W'(bus.done), W'(0));
            chk("rst_mid_busy", W'(bus.busy), W'(0));
            chk("rst_mid_result", bus.result, '0);
        end
        reset = 1'b1;
        rr_m  = 0;
        run_op(4'b0001, 4'b0000);

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < N; k++) begin
                a_m[k] = {$urandom, $urandom};
                b_m[k] = {$urandom, $urandom};
            end
            r = N'($urandom_range(1, (1 << N) - 1));
            d = ($urandom_range(0, 3) == 0) ? r : N'(0);
            run_op(r, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
